// File: rtl/uart_tx.sv
// uart_tx: byte-oriented UART transmitter (8 data bits, no parity, 1 or 2
// stop bits, LSB first) fed from a small write FIFO. The bit period is
// CLOCK_FREQUENCY / BAUD_RATE clock cycles (must be at least 2) and STOP_BITS
// must be 1 or 2. TxWire idles high and is driven straight from a flop.
module uart_tx #(
  parameter int CLOCK_FREQUENCY = 1_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int STOP_BITS       = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] TxDataInput,
  input  logic       TxWrite,
  output logic       TxFull,
  output logic       TxEmpty,
  output logic       TxBusy,
  output logic       TxWire
);

  localparam int BAUD_DIV      = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int FIFO_DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int STOP_CYCLES   = STOP_BITS * BAUD_DIV;
  // Wide enough to hold STOP_CYCLES - 1, the longest count reached.
  localparam int COUNTER_WIDTH = $clog2(STOP_CYCLES);

  localparam logic [COUNTER_WIDTH-1:0] BIT_LAST  = COUNTER_WIDTH'(BAUD_DIV - 1);
  localparam logic [COUNTER_WIDTH-1:0] STOP_LAST = COUNTER_WIDTH'(STOP_CYCLES - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txStateT;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]                 fifoMem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] writePointer;
  logic [FIFO_DEPTH_LOG2-1:0] readPointer;
  logic [FIFO_DEPTH_LOG2:0]   fifoCount;
  logic                       fifoPush;
  logic                       fifoPop;

  // Flags come from the registered count, so a pop in the same cycle never
  // lets a write into a full FIFO.
  assign TxFull   = (fifoCount == COUNT_FULL);
  assign TxEmpty  = (fifoCount == '0);
  assign fifoPush = TxWrite && !TxFull;

  // Byte storage: written on every accepted push.
  // NOTE: the array has no reset; fifoCount alone says which entries are
  // valid, so flushing only needs the pointers and count cleared.
  always_ff @(posedge Clk) begin
    if (fifoPush) begin
      fifoMem[writePointer] <= TxDataInput;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      writePointer <= '0;
      readPointer  <= '0;
      fifoCount    <= '0;
    end else begin
      if (fifoPush) writePointer <= writePointer + 1'b1;
      if (fifoPop)  readPointer  <= readPointer + 1'b1;
      case ({fifoPush, fifoPop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  txStateT                  state;
  txStateT                  nextState;
  logic [COUNTER_WIDTH-1:0] bitCounter;
  logic [COUNTER_WIDTH-1:0] nextBitCounter;
  logic [2:0]               bitIndex;
  logic [2:0]               nextBitIndex;
  logic [7:0]               shiftReg;
  logic [7:0]               nextShift;
  logic                     nextWire;

  assign TxBusy = (state != IDLE) || !TxEmpty;

  // State, bit timing and line registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      bitCounter <= '0;
      bitIndex   <= '0;
      shiftReg   <= '0;
      TxWire     <= 1'b1;
    end else begin
      state      <= nextState;
      bitCounter <= nextBitCounter;
      bitIndex   <= nextBitIndex;
      shiftReg   <= nextShift;
      TxWire     <= nextWire;
    end
  end

  // Next-state logic: the line value for the next bit is decided one cycle
  // ahead so TxWire itself only ever changes on a bit boundary.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and infers a latch.
    nextState      = state;
    nextBitCounter = bitCounter + 1'b1;
    nextBitIndex   = bitIndex;
    nextShift      = shiftReg;
    nextWire       = TxWire;
    fifoPop        = 1'b0;

    case (state)
      IDLE: begin
        nextWire       = 1'b1;
        nextBitCounter = '0;
        if (!TxEmpty) begin
          fifoPop      = 1'b1;
          nextShift    = fifoMem[readPointer];
          nextBitIndex = '0;
          nextWire     = 1'b0;
          nextState    = START;
        end
      end

      START: begin
        if (bitCounter == BIT_LAST) begin
          nextBitCounter = '0;
          nextWire       = shiftReg[0];
          nextState      = DATA;
        end
      end

      DATA: begin
        if (bitCounter == BIT_LAST) begin
          nextBitCounter = '0;
          if (bitIndex == 3'd7) begin
            nextWire  = 1'b1;
            nextState = STOP;
          end else begin
            nextShift    = {1'b0, shiftReg[7:1]};
            nextWire     = shiftReg[1];
            nextBitIndex = bitIndex + 1'b1;
          end
        end
      end

      STOP: begin
        if (bitCounter == STOP_LAST) begin
          nextBitCounter = '0;
          nextState      = IDLE;
        end
      end

      default: begin
        nextBitCounter = '0;
        nextWire       = 1'b1;
        nextState      = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at BAUD_DIV = 4. Two instances run
// on shared stimulus (STOP_BITS = 1 and 2); a line monitor decodes frames from
// the selected instance and compares them with the bytes queued by stimulus.
module tb_uart_tx;

  localparam int BAUD_DIV = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] TxDataInput;
  logic       TxWrite;

  logic TxFull1, TxEmpty1, TxBusy1, TxWire1;
  logic TxFull2, TxEmpty2, TxBusy2, TxWire2;

  uart_tx #(
    .CLOCK_FREQUENCY(1_000_000),
    .BAUD_RATE      (250_000),
    .FIFO_DEPTH_LOG2(2),
    .STOP_BITS      (1)
  ) dutOneStop (
    .Clk        (Clk),
    .Reset      (Reset),
    .TxDataInput(TxDataInput),
    .TxWrite    (TxWrite),
    .TxFull     (TxFull1),
    .TxEmpty    (TxEmpty1),
    .TxBusy     (TxBusy1),
    .TxWire     (TxWire1)
  );

  uart_tx #(
    .CLOCK_FREQUENCY(1_000_000),
    .BAUD_RATE      (250_000),
    .FIFO_DEPTH_LOG2(2),
    .STOP_BITS      (2)
  ) dutTwoStop (
    .Clk        (Clk),
    .Reset      (Reset),
    .TxDataInput(TxDataInput),
    .TxWrite    (TxWrite),
    .TxFull     (TxFull2),
    .TxEmpty    (TxEmpty2),
    .TxBusy     (TxBusy2),
    .TxWire     (TxWire2)
  );

  initial forever #5 Clk = ~Clk;

  // Selects which instance the monitor and the checks look at.
  bit   useTwo = 1'b0;
  logic monWire, monFull, monEmpty, monBusy;
  assign monWire  = useTwo ? TxWire2  : TxWire1;
  assign monFull  = useTwo ? TxFull2  : TxFull1;
  assign monEmpty = useTwo ? TxEmpty2 : TxEmpty1;
  assign monBusy  = useTwo ? TxBusy2  : TxBusy1;

  int cycle = 0;
  always @(posedge Clk) cycle <= cycle + 1;

  int         errorCount = 0;
  int         checkCount = 0;
  logic [7:0] expectedQueue [$];
  int         lastStart  = -1;
  int         firstStart = -1;
  int         curStart   = -1;
  bit         inFrame    = 1'b0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // Line monitor: sampled on the falling edge, half a cycle away from updates.
  initial begin : lineMonitor
    logic [7:0] rxByte;
    logic [7:0] wantByte;
    bit         glitch, stopOk, aborted;
    logic       idleWire, idleBusy;
    int         startCycle, stopCycles, stopBitsNow;
    forever begin
      @(negedge Clk);
      if (monWire === 1'b0) begin
        inFrame     = 1'b1;
        startCycle  = cycle;
        curStart    = cycle;
        glitch      = 1'b0;
        stopOk      = 1'b1;
        aborted     = (Reset === 1'b1);
        stopBitsNow = useTwo ? 2 : 1;
        stopCycles  = stopBitsNow * BAUD_DIV;
        rxByte      = '0;
        for (int s = 1; s < BAUD_DIV; s++) begin
          @(negedge Clk);
          if (Reset === 1'b1) aborted = 1'b1;
          if (monWire !== 1'b0) glitch = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
          @(negedge Clk);
          if (Reset === 1'b1) aborted = 1'b1;
          rxByte[k] = monWire;
          for (int s = 1; s < BAUD_DIV; s++) begin
            @(negedge Clk);
            if (Reset === 1'b1) aborted = 1'b1;
            if (monWire !== rxByte[k]) glitch = 1'b1;
          end
        end
        for (int s = 0; s < stopCycles; s++) begin
          @(negedge Clk);
          if (Reset === 1'b1) aborted = 1'b1;
          if (monWire !== 1'b1) stopOk = 1'b0;
        end
        // The cycle right after the stop bit(s) is always a single IDLE cycle.
        @(negedge Clk);
        idleWire = monWire;
        idleBusy = monBusy;
        if (!aborted) begin
          check("frame_expected", 32'(expectedQueue.size() != 0), 32'd1);
          if (expectedQueue.size() != 0) begin
            wantByte = expectedQueue.pop_front();
            check("frame_data", 32'(rxByte), 32'(wantByte));
          end
          check("frame_stable", 32'(glitch), 32'd0);
          check("stop_high", 32'(stopOk), 32'd1);
          if (lastStart >= 0) begin
            check("start_gap", 32'(startCycle - lastStart), 32'((9 + stopBitsNow) * BAUD_DIV + 1));
          end else begin
            firstStart = startCycle;
          end
          lastStart = startCycle;
          check("idle_gap_wire", 32'(idleWire), 32'd1);
          check("busy_after_frame", 32'(idleBusy), 32'(expectedQueue.size() != 0));
        end
        inFrame = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyReset();
    Reset   = 1'b1;
    TxWrite = 1'b0;
    tick();
    Reset      = 1'b0;
    lastStart  = -1;
    firstStart = -1;
  endtask

  task automatic writeByte(input logic [7:0] data, input bit expectSent);
    TxDataInput = data;
    TxWrite     = 1'b1;
    if (expectSent) expectedQueue.push_back(data);
    tick();
    TxWrite = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expectedQueue.size() != 0 || inFrame || monBusy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
  endtask

  initial begin : stimulus
    int wrCycle;
    int n;
    Reset       = 1'b1;
    TxWrite     = 1'b0;
    TxDataInput = '0;
    tick();
    applyReset();

    // Reset state.
    check("reset_wire", 32'(monWire), 32'd1);
    check("reset_full", 32'(monFull), 32'd0);
    check("reset_empty", 32'(monEmpty), 32'd1);
    check("reset_busy", 32'(monBusy), 32'd0);

    // Single byte 0xA5: start bit two edges after the write.
    wrCycle = cycle;
    writeByte(8'hA5, 1'b1);
    check("a5_empty_after_write", 32'(monEmpty), 32'd0);
    check("a5_busy_after_write", 32'(monBusy), 32'd1);
    check("a5_wire_before_pop", 32'(monWire), 32'd1);
    waitDrain(200);
    check("a5_latency", 32'(firstStart - wrCycle), 32'd2);
    check("a5_idle_wire", 32'(monWire), 32'd1);
    check("a5_idle_empty", 32'(monEmpty), 32'd1);

    // Six consecutive writes: the sixth hits a full FIFO and is dropped.
    applyReset();
    writeByte(8'h00, 1'b1);
    writeByte(8'hFF, 1'b1);
    writeByte(8'h55, 1'b1);
    writeByte(8'h80, 1'b1);
    writeByte(8'h3C, 1'b1);
    check("six_full_after_5th", 32'(monFull), 32'd1);
    writeByte(8'h99, 1'b0);
    check("six_full_after_6th", 32'(monFull), 32'd1);
    waitDrain(400);
    repeat (60) tick();
    check("six_no_extra_frame", 32'(expectedQueue.size()), 32'd0);
    check("six_idle_busy", 32'(monBusy), 32'd0);

    // Reset during data bit 3 of 0xF0 with two bytes queued behind it.
    applyReset();
    writeByte(8'hF0, 1'b0);
    writeByte(8'h11, 1'b0);
    writeByte(8'h22, 1'b0);
    n = 0;
    while (!inFrame && n < 20) begin
      tick();
      n++;
    end
    check("rst_frame_started", 32'(inFrame), 32'd1);
    n = 0;
    while (cycle < curStart + 16 && n < 40) begin
      tick();
      n++;
    end
    check("rst_wire_in_bit3", 32'(monWire), 32'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    lastStart  = -1;
    firstStart = -1;
    check("rst_mid_wire", 32'(monWire), 32'd1);
    check("rst_mid_empty", 32'(monEmpty), 32'd1);
    check("rst_mid_busy", 32'(monBusy), 32'd0);
    check("rst_mid_full", 32'(monFull), 32'd0);
    // Reset wins over a write presented in the same cycle.
    Reset       = 1'b1;
    TxWrite     = 1'b1;
    TxDataInput = 8'h77;
    tick();
    Reset   = 1'b0;
    TxWrite = 1'b0;
    check("rst_overrides_write", 32'(monEmpty), 32'd1);
    repeat (150) tick();
    check("rst_line_stays_high", 32'(monWire), 32'd1);
    check("rst_stays_idle", 32'(monBusy), 32'd0);
    writeByte(8'h5A, 1'b1);
    waitDrain(200);

    // Write on the same edge as a pop from a full FIFO is dropped.
    applyReset();
    writeByte(8'hA1, 1'b1);
    writeByte(8'hB2, 1'b1);
    writeByte(8'hC3, 1'b1);
    writeByte(8'hD4, 1'b1);
    writeByte(8'hE5, 1'b1);
    check("fp_full", 32'(monFull), 32'd1);
    TxDataInput = 8'hF6;
    TxWrite     = 1'b1;
    n = 0;
    while (monFull === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    TxWrite = 1'b0;
    check("fp_full_released", 32'(n < 200), 32'd1);
    tick();
    check("fp_not_full_after_pop", 32'(monFull), 32'd0);
    check("fp_not_empty_after_pop", 32'(monEmpty), 32'd0);
    waitDrain(400);

    // Two stop bits, 0x01 followed by a queued 0x02.
    useTwo = 1'b1;
    applyReset();
    check("two_reset_wire", 32'(monWire), 32'd1);
    writeByte(8'h01, 1'b1);
    writeByte(8'h02, 1'b1);
    waitDrain(300);
    check("two_idle_empty", 32'(monEmpty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
